// File: rtl/bus_mux_pipe_if.sv
// Bus-side bundle of bus_mux_pipe: source requests/data in, registered bus out.
// master = bus sources + consumer, slave = the mux itself.
interface bus_mux_pipe_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int SELW  = $clog2(NSRC),
  parameter int CNTW  = 8
);
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_out;
  logic                  mode;
  logic                  hold_en;
  logic                  bus_ready;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [SELW-1:0]       bus_sel;
  logic                  conflict;
  logic [CNTW-1:0]       conflict_count;

  modport master (
    output src_data, src_out, mode, hold_en, bus_ready,
    input  bus_out, bus_valid, bus_sel, conflict, conflict_count
  );

  modport slave (
    input  src_data, src_out, mode, hold_en, bus_ready,
    output bus_out, bus_valid, bus_sel, conflict, conflict_count
  );
endinterface

// File: rtl/bus_mux_pipe.sv
// Registered NSRC:1 bus multiplexer with fixed-priority / round-robin arbitration,
// valid/ready output stage and saturating multi-driver conflict counter.
module bus_mux_pipe #(
  parameter int WIDTH       = 32,
  parameter int NSRC        = 24,
  parameter int SELW        = $clog2(NSRC),
  parameter int DEFAULT_SRC = NSRC-1,
  parameter int CNTW        = 8
) (
  input  logic          clock,
  input  logic          clear,
  bus_mux_pipe_if.slave bus
);
  logic [NSRC-1:0][WIDTH-1:0] srcArr;
  logic [WIDTH-1:0]           busOut;
  logic                       busValid;
  logic [SELW-1:0]            busSel;
  logic                       conflictQ;
  logic [CNTW-1:0]            conflictCnt;
  logic [SELW-1:0]            rrPtr;

  logic [SELW-1:0] prioGrant, rrGrant, grant;
  logic            rrFound, anyReq, multiReq, loadEdge;
  int              rrIdx;

  for (genvar g = 0; g < NSRC; g++) begin : gUnpack
    assign srcArr[g] = bus.src_data[g*WIDTH +: WIDTH];
  end

  always_comb begin
    prioGrant = '0;
    rrGrant   = '0;
    rrFound   = 1'b0;
    rrIdx     = 0;
    // Descending scan leaves the lowest set index as the final assignment.
    for (int i = NSRC-1; i >= 0; i--)
      if (bus.src_out[SELW'(i)]) prioGrant = SELW'(i);
    // Search starts one past the last round-robin winner, wrapping at NSRC.
    for (int k = 0; k < NSRC; k++) begin
      rrIdx = (int'(rrPtr) + 1 + k) % NSRC;
      if (!rrFound && bus.src_out[SELW'(rrIdx)]) begin
        rrGrant = SELW'(rrIdx);
        rrFound = 1'b1;
      end
    end
  end

  assign grant    = bus.mode ? rrGrant : prioGrant;
  assign anyReq   = |bus.src_out;
  assign multiReq = $countones(bus.src_out) > 1;
  assign loadEdge = !busValid || bus.bus_ready;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      busOut      <= '0;
      busValid    <= 1'b0;
      busSel      <= '0;
      conflictQ   <= 1'b0;
      conflictCnt <= '0;
      rrPtr       <= SELW'(NSRC-1);
    end else if (loadEdge) begin
      conflictQ <= multiReq;
      if (multiReq && conflictCnt != '1) conflictCnt <= conflictCnt + 1'b1;
      if (anyReq) begin
        busOut   <= srcArr[grant];
        busSel   <= grant;
        busValid <= 1'b1;
        if (bus.mode) rrPtr <= grant;
      end else begin
        busValid <= 1'b0;
        if (!bus.hold_en) begin
          busOut <= srcArr[DEFAULT_SRC];
          busSel <= SELW'(DEFAULT_SRC);
        end
      end
    end
  end

  assign bus.bus_out        = busOut;
  assign bus.bus_valid      = busValid;
  assign bus.bus_sel        = busSel;
  assign bus.conflict       = conflictQ;
  assign bus.conflict_count = conflictCnt;
endmodule

// File: tb/tb_bus_mux_pipe.sv
// Self-checking bench for bus_mux_pipe: vector table plus hand-built stall,
// idle, async-reset and counter-saturation sequences, checked via a scoreboard queue.
module tb_bus_mux_pipe;
  localparam int W = 32;
  localparam int N = 24;

  typedef struct {
    logic [W-1:0] out;
    logic [4:0]   sel;
    logic         valid;
    logic         conf;
    logic [7:0]   cnt;
  } exp_t;

  typedef struct {
    logic [N-1:0] src;
    logic         mode;
    logic         hold;
    logic [4:0]   sel;
    logic         valid;
    logic         conf;
  } vec_t;

  logic clock = 1'b0;
  logic clear;
  logic [W-1:0] dat [N];
  exp_t sbq [$];
  vec_t tbl [12];
  int   nVec = 0;
  int   nErr = 0;
  int   mcnt = 0;

  always #5 clock = ~clock;

  bus_mux_pipe_if #(.WIDTH(W), .NSRC(N), .CNTW(8)) bif ();
  bus_mux_pipe #(.WIDTH(W), .NSRC(N), .CNTW(8)) dut (.clock(clock), .clear(clear), .bus(bif));

  always_comb begin
    bif.src_data = '0;
    for (int i = 0; i < N; i++) bif.src_data[i*W +: W] = dat[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkZero(input string tag);
    chk({tag, " bus_out"}, bif.bus_out, 32'h0);
    chk({tag, " bus_valid"}, 32'(bif.bus_valid), 32'h0);
    chk({tag, " bus_sel"}, 32'(bif.bus_sel), 32'h0);
    chk({tag, " conflict"}, 32'(bif.conflict), 32'h0);
    chk({tag, " conflict_count"}, 32'(bif.conflict_count), 32'h0);
  endtask

  task automatic step(input string nm, input logic [N-1:0] s, input logic m, input logic h,
                      input logic r, input exp_t e);
    exp_t x;
    bif.src_out   = s;
    bif.mode      = m;
    bif.hold_en   = h;
    bif.bus_ready = r;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    x = sbq.pop_front();
    chk({nm, " bus_out"}, bif.bus_out, x.out);
    chk({nm, " bus_sel"}, 32'(bif.bus_sel), 32'(x.sel));
    chk({nm, " bus_valid"}, 32'(bif.bus_valid), 32'(x.valid));
    chk({nm, " conflict"}, 32'(bif.conflict), 32'(x.conf));
    chk({nm, " conflict_count"}, 32'(bif.conflict_count), 32'(x.cnt));
  endtask

  initial begin
    for (int i = 0; i < N; i++) dat[i] = 32'hC0DE_0000 | i;
    dat[2]  = 32'h0000_00AA;
    dat[7]  = 32'h1234_5678;
    dat[23] = 32'hFFFF_FFF0;

    // src, mode, hold, expected sel, valid, conflict
    tbl[0]  = '{24'h000024, 1'b0, 1'b0, 5'd2,  1'b1, 1'b1};
    tbl[1]  = '{24'h000080, 1'b0, 1'b0, 5'd7,  1'b1, 1'b0};
    tbl[2]  = '{24'h800009, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1};
    tbl[3]  = '{24'h800009, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1};
    tbl[4]  = '{24'h800009, 1'b1, 1'b0, 5'd3,  1'b1, 1'b1};
    tbl[5]  = '{24'h800009, 1'b1, 1'b0, 5'd23, 1'b1, 1'b1};
    tbl[6]  = '{24'h800009, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1};
    tbl[7]  = '{24'h000010, 1'b1, 1'b0, 5'd4,  1'b1, 1'b0};
    tbl[8]  = '{24'h000012, 1'b1, 1'b0, 5'd1,  1'b1, 1'b1};
    tbl[9]  = '{24'h000000, 1'b0, 1'b1, 5'd1,  1'b0, 1'b0};
    tbl[10] = '{24'h000000, 1'b0, 1'b0, 5'd23, 1'b0, 1'b0};
    tbl[11] = '{24'h000012, 1'b0, 1'b0, 5'd1,  1'b1, 1'b1};

    clear         = 1'b0;
    bif.src_out   = '0;
    bif.mode      = 1'b0;
    bif.hold_en   = 1'b0;
    bif.bus_ready = 1'b1;
    #2;
    chkZero("reset");
    #6 clear = 1'b1;
    step("release idle", '0, 1'b0, 1'b0, 1'b1, '{dat[23], 5'd23, 1'b0, 1'b0, 8'd0});

    for (int v = 0; v < 12; v++) begin
      if (tbl[v].conf) mcnt++;
      step($sformatf("vec%0d", v), tbl[v].src, tbl[v].mode, tbl[v].hold, 1'b1,
           '{dat[tbl[v].sel], tbl[v].sel, tbl[v].valid, tbl[v].conf, 8'(mcnt)});
    end

    // Stall: source 7 held on the bus while source 9 waits.
    step("stall load", 24'h000080, 1'b0, 1'b0, 1'b1, '{32'h1234_5678, 5'd7, 1'b1, 1'b0, 8'(mcnt)});
    for (int s = 0; s < 3; s++)
      step($sformatf("stall%0d", s), 24'h000200, 1'b0, 1'b0, 1'b0,
           '{32'h1234_5678, 5'd7, 1'b1, 1'b0, 8'(mcnt)});
    step("stall release", 24'h000200, 1'b0, 1'b0, 1'b1, '{dat[9], 5'd9, 1'b1, 1'b0, 8'(mcnt)});

    // Idle behaviour with and without hold.
    dat[5] = 32'hDEAD_BEEF;
    step("idle load", 24'h000020, 1'b0, 1'b0, 1'b1, '{32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 8'(mcnt)});
    step("idle hold", '0, 1'b0, 1'b1, 1'b1, '{32'hDEAD_BEEF, 5'd5, 1'b0, 1'b0, 8'(mcnt)});
    step("idle default", '0, 1'b0, 1'b0, 1'b1, '{32'hFFFF_FFF0, 5'd23, 1'b0, 1'b0, 8'(mcnt)});

    // Asynchronous reset in the middle of a stall.
    step("pre-reset load", 24'h000080, 1'b0, 1'b0, 1'b1, '{32'h1234_5678, 5'd7, 1'b1, 1'b0, 8'(mcnt)});
    bif.bus_ready = 1'b0;
    bif.src_out   = 24'h000200;
    #3 clear = 1'b0;
    #1;
    chkZero("mid-stall reset");
    mcnt = 0;
    #2 clear = 1'b1;
    step("post-reset idle", '0, 1'b0, 1'b0, 1'b1, '{dat[23], 5'd23, 1'b0, 1'b0, 8'd0});
    mcnt++;
    step("post-reset rr", 24'h000401, 1'b1, 1'b0, 1'b1, '{dat[0], 5'd0, 1'b1, 1'b1, 8'(mcnt)});

    // Counter saturation under a persistent two-source conflict.
    for (int i = 0; i < 300; i++) begin
      if (mcnt < 255) mcnt++;
      step($sformatf("sat%0d", i), 24'h000003, 1'b0, 1'b0, 1'b1,
           '{dat[0], 5'd0, 1'b1, 1'b1, 8'(mcnt)});
    end
    chk("sat final", 32'(bif.conflict_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
